// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request port between the instruction-fetch
// (IF) and load/store (LS) requesters with round-robin arbitration and a single
// outstanding transaction. A response watchdog returns a zero response and sets a
// sticky bus_err when memory fails to answer in time.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   if_req_*/if_addr                IF read request (handshake, address)
//   if_rsp_valid/if_rdata           IF response pulse and data
//   ls_req_*/ls_addr/wen/wdata/wmask LS request (handshake, address, write payload)
//   ls_rsp_valid/ls_rdata           LS response pulse and data
//   mem_req_*/mem_addr/wen/wdata/wmask downstream request, held until accepted
//   mem_rsp_valid/mem_rdata         downstream response
//   bus_err                         sticky watchdog timeout flag
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_grant, owner;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    logic              grant_c, grant_src_c;
    logic              rsp_hit_c, timeout_c, rsp_any_c;
    logic [DATA_W-1:0] rsp_data_c;

    // State register, captured request, watchdog counter, sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= SRC_LS;
            owner      <= SRC_IF;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_c) begin
                owner      <= grant_src_c;
                last_grant <= grant_src_c;
                if (grant_src_c == SRC_LS) begin
                    addr_q  <= ls_addr;
                    wen_q   <= ls_wen;
                    wdata_q <= ls_wdata;
                    wmask_q <= ls_wmask;
                end else begin
                    addr_q  <= if_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (state == S_REQ && mem_req_ready) begin
                cnt <= '0;
            end else if (state == S_WAIT && !rsp_any_c && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timeout_c) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Arbitration, next state and handshake/response outputs
    always_comb begin
        state_nxt     = state;
        grant_c       = 1'b0;
        grant_src_c   = SRC_IF;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        rsp_hit_c     = 1'b0;
        timeout_c     = 1'b0;

        case (state)
            S_IDLE: begin
                // Ready is combinational; gate with rst so outputs drop during reset
                if (!rst) begin
                    if (if_req_valid && ls_req_valid) begin
                        grant_c     = 1'b1;
                        grant_src_c = ~last_grant;
                    end else if (if_req_valid) begin
                        grant_c     = 1'b1;
                        grant_src_c = SRC_IF;
                    end else if (ls_req_valid) begin
                        grant_c     = 1'b1;
                        grant_src_c = SRC_LS;
                    end
                end
                if (grant_c) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                mem_wen       = wen_q;
                mem_wdata     = wdata_q;
                mem_wmask     = wmask_q;
                if (mem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response wins over a timeout in the same cycle
                if (mem_rsp_valid) begin
                    rsp_hit_c = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_c = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if_req_ready = grant_c && (grant_src_c == SRC_IF);
        ls_req_ready = grant_c && (grant_src_c == SRC_LS);
    end

    assign rsp_any_c  = rsp_hit_c | timeout_c;
    assign rsp_data_c = rsp_hit_c ? mem_rdata : '0;

    assign if_rsp_valid = rsp_any_c && (owner == SRC_IF);
    assign ls_rsp_valid = rsp_any_c && (owner == SRC_LS);
    assign if_rdata     = if_rsp_valid ? rsp_data_c : '0;
    assign ls_rdata     = ls_rsp_valid ? rsp_data_c : '0;

endmodule
